ahb_master_arbiter: RTL
=======================

AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0, meaning 0 = round-robin and 1 = M1 (data) always wins.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-003 SHALL have port HCLK  input  1  the single clock; all flops on its rising edge.
REQ-004 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports HADDR_M0/M1  input  ADDR_W  master address.
REQ-006 SHALL have ports HTRANS_M0/M1  input  2  master transfer type.
REQ-007 SHALL have ports HWRITE_M0/M1  input  1  master write flag.
REQ-008 SHALL have ports HSIZE_M0/M1  input  3  master transfer size.
REQ-009 SHALL have ports HWDATA_M0/M1  input  32  master write data.
REQ-010 SHALL have ports HRDATA_M0/M1  output  32  read data returned to each master.
REQ-011 SHALL have ports HREADY_M0/M1  output  1  per-master ready/stall.
REQ-012 SHALL have ports HSEL_S, HADDR_S, HTRANS_S, HWRITE_S, HSIZE_S, HWDATA_S  output  1/ADDR_W/2/1/3/32  shared-slave address and data phase.
REQ-013 SHALL have port HREADY_S  output  1  equal to HREADYOUT_S.
REQ-014 SHALL have ports HRDATA_S  input  32  and HREADYOUT_S  input  1  slave response.
REQ-015 SHALL have port OWNER  output  2  data-phase owner: 00 none, 01 M0, 10 M1.

Function
REQ-016 SHALL hold, per master x, a one-entry register (addr, write, size) plus a valid flag pend_x.
REQ-017 SHALL compute request r_x = pend_x | (HREADY_Mx & HTRANS_Mx[1]); IDLE and BUSY transfers are never requests.
REQ-018 SHALL arbitrate only on edges where HREADYOUT_S=1; the grant is combinational in the same cycle.
REQ-019 SHALL, with a single requester, grant that requester.
REQ-020 SHALL, with both requesting, grant the master not granted last when FIXED_PRIO=0, and grant M1 when FIXED_PRIO=1.
REQ-021 SHALL drive the slave address phase from the holding register when pend_x=1, otherwise from the live master bus.
REQ-022 SHALL force HTRANS_S=NONSEQ and HSEL_S=1 when a grant exists, and HTRANS_S=IDLE and HSEL_S=0 when none exists.
REQ-023 SHALL re-arbitrate every burst beat as an independent transfer.
REQ-024 SHALL, on an edge with HREADY_Mx=1 and HTRANS_Mx[1]=1 where x is not granted, set pend_x and capture the address phase.
REQ-025 SHALL clear pend_x on the edge its request is granted with HREADYOUT_S=1.
REQ-026 SHALL set the data-phase owner register to the granted master, or none, on every edge with HREADYOUT_S=1, and hold it otherwise.
REQ-027 SHALL drive HREADY_Mx = HREADYOUT_S when owner==x, else ~pend_x.
REQ-028 SHALL drive HWDATA_S from the owner's HWDATA, and 0 when the owner is none.
REQ-029 SHALL drive HRDATA_M0 = HRDATA_M1 = HRDATA_S at all times; data is valid only to the owner.
REQ-030 SHALL accept a master's next address phase while its own data phase completes (HREADYOUT_S=1), with no idle cycle inserted.
REQ-031 SHALL freeze both address-phase outputs and grant decisions while HREADYOUT_S=0; a live request arriving then is captured per REQ-024 and is not lost.
REQ-032 SHALL bound the wait of a requester to one foreign transfer when FIXED_PRIO=0.

Reset
REQ-033 SHALL asynchronously clear pend_M0, pend_M1 and owner=00, and set last-grant=M1 so M0 wins the first tie.
REQ-034 SHALL hold outputs HREADY_M0/M1=1, HTRANS_S=IDLE, HSEL_S=0, HWDATA_S=0 and OWNER=00 during and immediately after reset.
REQ-035 SHALL discard any in-flight transfer on reset assertion mid-operation, with no replay after release.

Verification
REQ-036 SHALL pass: M0-only read of 0x100, slave zero-wait -> HADDR_S=0x100 same cycle, OWNER=01 next cycle, HRDATA_M0 = slave data, HREADY_M0 never low.
REQ-037 SHALL pass: M0 and M1 both NONSEQ in the same cycle after reset with FIXED_PRIO=0 -> M0 granted first, pend_M1=1, HREADY_M1=0 for one cycle, M1 granted next cycle.
REQ-038 SHALL pass: same stimulus with FIXED_PRIO=1 -> M1 granted first and M0 held pending.
REQ-039 SHALL pass: both masters streaming continuously with FIXED_PRIO=0 -> grants alternate M0,M1,M0,M1 and neither master waits more than one transfer.
REQ-040 SHALL pass: slave HREADYOUT_S=0 for 3 cycles during an M1 write of 0xCAFEF00D -> HWDATA_S stable at 0xCAFEF00D, HREADY_M1=0 for 3 cycles, an M0 request arriving during the stall is captured and granted at completion.
REQ-041 SHALL pass: HRESETn asserted while pend_M1=1 and owner=M0 -> outputs return to reset values asynchronously, and after release no transfer is issued without a new request.

Source files
------------

// File: rtl/ahb_master_arbiter_if.sv
// Bus bundle for the two-master AHB arbiter: both master ports, the shared slave port and the owner tag.
// The arbiter connects through the slave modport and the bus masters/slave model through the master modport.
interface ahb_master_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] HADDR_M0, HADDR_M1;
    logic [1:0]        HTRANS_M0, HTRANS_M1;
    logic              HWRITE_M0, HWRITE_M1;
    logic [2:0]        HSIZE_M0, HSIZE_M1;
    logic [31:0]       HWDATA_M0, HWDATA_M1;
    logic [31:0]       HRDATA_M0, HRDATA_M1;
    logic              HREADY_M0, HREADY_M1;

    logic              HSEL_S;
    logic [ADDR_W-1:0] HADDR_S;
    logic [1:0]        HTRANS_S;
    logic              HWRITE_S;
    logic [2:0]        HSIZE_S;
    logic [31:0]       HWDATA_S;
    logic              HREADY_S;
    logic [31:0]       HRDATA_S;
    logic              HREADYOUT_S;

    logic [1:0]        OWNER;

    modport slave (
        input  HADDR_M0, HADDR_M1, HTRANS_M0, HTRANS_M1, HWRITE_M0, HWRITE_M1,
               HSIZE_M0, HSIZE_M1, HWDATA_M0, HWDATA_M1, HRDATA_S, HREADYOUT_S,
        output HRDATA_M0, HRDATA_M1, HREADY_M0, HREADY_M1, HSEL_S, HADDR_S,
               HTRANS_S, HWRITE_S, HSIZE_S, HWDATA_S, HREADY_S, OWNER
    );

    modport master (
        output HADDR_M0, HADDR_M1, HTRANS_M0, HTRANS_M1, HWRITE_M0, HWRITE_M1,
               HSIZE_M0, HSIZE_M1, HWDATA_M0, HWDATA_M1, HRDATA_S, HREADYOUT_S,
        input  HRDATA_M0, HRDATA_M1, HREADY_M0, HREADY_M1, HSEL_S, HADDR_S,
               HTRANS_S, HWRITE_S, HSIZE_S, HWDATA_S, HREADY_S, OWNER
    );
endinterface

// File: rtl/ahb_master_arbiter.sv
// Two-master to one-slave AHB arbiter: a losing or stalled address phase is parked in a
// one-entry holding register and replayed when granted; grants alternate (or favour M1).
module ahb_master_arbiter #(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int ADDR_W     = 32
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahb_master_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_M0   = 2'b01,
        SEL_M1   = 2'b10
    } sel_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    sel_e              r_owner, r_last, r_gnt_q, w_gnt;
    logic              r_wait;
    logic              r_pend0, r_pend1;
    logic [ADDR_W-1:0] r_addr0, r_addr1;
    logic              r_write0, r_write1;
    logic [2:0]        r_size0, r_size1;

    logic w_rdy0, w_rdy1, w_live0, w_live1, w_req0, w_req1, w_adv;
    wire  w_unused = ^{bus.HTRANS_M0[0], bus.HTRANS_M1[0]};

    assign w_adv   = bus.HREADYOUT_S;
    assign w_rdy0  = (r_owner == SEL_M0) ? bus.HREADYOUT_S : ~r_pend0;
    assign w_rdy1  = (r_owner == SEL_M1) ? bus.HREADYOUT_S : ~r_pend1;
    assign w_live0 = w_rdy0 & bus.HTRANS_M0[1];
    assign w_live1 = w_rdy1 & bus.HTRANS_M1[1];
    // Gating with HRESETn keeps the slave idle even if a master drives NONSEQ during reset.
    assign w_req0  = HRESETn & (r_pend0 | w_live0);
    assign w_req1  = HRESETn & (r_pend1 | w_live1);

    // A grant made in a waited cycle was parked, so it is replayed unchanged until the slave is ready.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_gnt = SEL_NONE;
        if (r_wait && (r_gnt_q != SEL_NONE))
            w_gnt = r_gnt_q;
        else if (w_req0 && w_req1)
            w_gnt = (FIXED_PRIO || (r_last == SEL_M0)) ? SEL_M1 : SEL_M0;
        else if (w_req0)
            w_gnt = SEL_M0;
        else if (w_req1)
            w_gnt = SEL_M1;
    end

    always_comb begin
        bus.HSEL_S   = 1'b0;
        bus.HTRANS_S = HTRANS_IDLE;
        bus.HADDR_S  = '0;
        bus.HWRITE_S = 1'b0;
        bus.HSIZE_S  = 3'b000;
        unique case (w_gnt)
            SEL_M0: begin
                bus.HSEL_S   = 1'b1;
                bus.HTRANS_S = HTRANS_NONSEQ;
                bus.HADDR_S  = r_pend0 ? r_addr0  : bus.HADDR_M0;
                bus.HWRITE_S = r_pend0 ? r_write0 : bus.HWRITE_M0;
                bus.HSIZE_S  = r_pend0 ? r_size0  : bus.HSIZE_M0;
            end
            SEL_M1: begin
                bus.HSEL_S   = 1'b1;
                bus.HTRANS_S = HTRANS_NONSEQ;
                bus.HADDR_S  = r_pend1 ? r_addr1  : bus.HADDR_M1;
                bus.HWRITE_S = r_pend1 ? r_write1 : bus.HWRITE_M1;
                bus.HSIZE_S  = r_pend1 ? r_size1  : bus.HSIZE_M1;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.HWDATA_S = 32'h0;
        unique case (r_owner)
            SEL_M0:  bus.HWDATA_S = bus.HWDATA_M0;
            SEL_M1:  bus.HWDATA_S = bus.HWDATA_M1;
            default: ;
        endcase
    end

    assign bus.HREADY_M0 = w_rdy0;
    assign bus.HREADY_M1 = w_rdy1;
    assign bus.HRDATA_M0 = bus.HRDATA_S;
    assign bus.HRDATA_M1 = bus.HRDATA_S;
    assign bus.HREADY_S  = bus.HREADYOUT_S;
    assign bus.OWNER     = r_owner;

    // A live phase seen by its master as accepted, but not taken by the slave, is parked.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_owner  <= SEL_NONE;
            r_last   <= SEL_M1;
            r_gnt_q  <= SEL_NONE;
            r_wait   <= 1'b0;
            r_pend0  <= 1'b0;
            r_pend1  <= 1'b0;
            r_addr0  <= '0;
            r_addr1  <= '0;
            r_write0 <= 1'b0;
            r_write1 <= 1'b0;
            r_size0  <= 3'b000;
            r_size1  <= 3'b000;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values of the others.
            r_gnt_q <= w_gnt;
            r_wait  <= ~w_adv;
            if (w_adv) begin
                r_owner <= w_gnt;
                if (w_gnt != SEL_NONE)
                    r_last <= w_gnt;
            end

            if (w_adv && (w_gnt == SEL_M0)) begin
                r_pend0 <= 1'b0;
            end else if (w_live0 && !r_pend0) begin
                r_pend0  <= 1'b1;
                r_addr0  <= bus.HADDR_M0;
                r_write0 <= bus.HWRITE_M0;
                r_size0  <= bus.HSIZE_M0;
            end

            if (w_adv && (w_gnt == SEL_M1)) begin
                r_pend1 <= 1'b0;
            end else if (w_live1 && !r_pend1) begin
                r_pend1  <= 1'b1;
                r_addr1  <= bus.HADDR_M1;
                r_write1 <= bus.HWRITE_M1;
                r_size1  <= bus.HSIZE_M1;
            end
        end
    end
endmodule
